matrix_scan_controller: RTL

MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

---
 rtl/matrix_scan_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_controller.sv
// LED matrix row-scan controller with double-buffered row storage.
// The FSM drives an external shift-register driver: it loads one row,
// waits for the shift to complete, blanks, and then lights the row.
// The front buffer is displayed and the back buffer is written.
// Swaps between the two buffers are deferred to the frame boundary.
module matrix_scan_controller #(
  parameter int ON_CYCLES     = 1024,
  parameter int BLANK_CYCLES  = 8,
  parameter int SHIFT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [63:0] wr_data,
  input  logic        swap_req,
  input  logic        shift_done,
  output logic        shift_start,
  output logic [63:0] shift_data,
  output logic [7:0]  row_sel,
  output logic        oe_n,
  output logic        swap_ack,
  output logic        frame_tick,
  output logic        err_timeout
);

  localparam int MAX_A = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int MAX_C = (MAX_A > SHIFT_TIMEOUT) ? MAX_A : SHIFT_TIMEOUT;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] ON_PRE     = CW'(ON_CYCLES - 2);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(SHIFT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, BLANK, SHOW} state_t;

  state_t        state_reg;
  logic [2:0]    row_reg;
  logic [CW-1:0] cnt_reg;
  logic          front_sel_reg;
  logic          swap_pending_reg;
  logic          shift_start_reg;
  logic [63:0]   shift_data_reg;
  logic [7:0]    row_sel_reg;
  logic          oe_n_reg;
  logic          frame_tick_reg;
  logic          err_timeout_reg;

  // Both buffers in one array: index bit 3 selects the buffer, bits 2:0 the row.
  logic [63:0]   mem_reg [0:15];
  logic [3:0]    wr_addr;
  logic          do_swap;

  // Writes always land in whichever buffer is currently the back buffer.
  // In the swap cycle this is still the pre-swap back buffer.
  assign wr_addr = {~front_sel_reg, wr_row};

  // frame_tick is high during the last SHOW cycle of row 7.
  // A swap_req arriving in that same cycle still counts for this frame,
  // so the acknowledge cannot be registered ahead of time.
  assign do_swap = frame_tick_reg & ~rst & (swap_pending_reg | swap_req);

  assign shift_start = shift_start_reg;
  assign shift_data  = shift_data_reg;
  assign row_sel     = row_sel_reg;
  assign oe_n        = oe_n_reg;
  assign swap_ack    = do_swap;
  assign frame_tick  = frame_tick_reg;
  assign err_timeout = err_timeout_reg;

  // Row storage: cleared by reset, written only through the back-buffer port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Scan FSM. Outputs are updated on the transition into each state,
  // so they line up with the state being occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      row_reg          <= 3'd0;
      cnt_reg          <= '0;
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
      shift_start_reg  <= 1'b0;
      shift_data_reg   <= '0;
      row_sel_reg      <= 8'd0;
      oe_n_reg         <= 1'b1;
      frame_tick_reg   <= 1'b0;
      err_timeout_reg  <= 1'b0;
    end else begin
      shift_start_reg <= 1'b0;
      frame_tick_reg  <= 1'b0;
      if (swap_req) begin
        swap_pending_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          state_reg       <= LOAD;
          row_reg         <= 3'd0;
          shift_start_reg <= 1'b1;
          shift_data_reg  <= mem_reg[{front_sel_reg, 3'd0}];
        end
        LOAD: begin
          state_reg <= WAIT;
          cnt_reg   <= '0;
        end
        WAIT: begin
          if (shift_done || cnt_reg == WAIT_LAST) begin
            if (!shift_done) begin
              err_timeout_reg <= 1'b1;
            end
            state_reg <= BLANK;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_reg      <= SHOW;
            cnt_reg        <= '0;
            oe_n_reg       <= 1'b0;
            row_sel_reg    <= 8'd1 << row_reg;
            frame_tick_reg <= (row_reg == 3'd7) && (ON_CYCLES == 1);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_reg == ON_LAST) begin
            state_reg       <= LOAD;
            oe_n_reg        <= 1'b1;
            row_sel_reg     <= 8'd0;
            shift_start_reg <= 1'b1;
            if (row_reg == 3'd7) begin
              // Frame end: row 0 of the next frame comes from the post-swap front.
              row_reg        <= 3'd0;
              shift_data_reg <= mem_reg[{front_sel_reg ^ do_swap, 3'd0}];
              if (do_swap) begin
                front_sel_reg    <= ~front_sel_reg;
                swap_pending_reg <= 1'b0;
              end
            end else begin
              row_reg        <= row_reg + 3'd1;
              shift_data_reg <= mem_reg[{front_sel_reg, row_reg + 3'd1}];
            end
          end else begin
            cnt_reg        <= cnt_reg + CW'(1);
            frame_tick_reg <= (row_reg == 3'd7) && (cnt_reg == ON_PRE);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
